// File: rtl/av_dev_demux_if.sv
// Upstream bus and device-side fan-out signals of av_dev_demux.
// slave = demux view, master = upstream host plus device models.
interface av_dev_demux_if #(
  parameter int NDEV = 4
);
  logic                 s_cyc_i;
  logic                 s_stb_i;
  logic                 s_we_i;
  logic [3:0]           s_sel_i;
  logic [31:0]          s_adr_i;
  logic [31:0]          s_dat_i;
  logic                 s_ack_o;
  logic                 s_stall_o;
  logic [31:0]          s_dat_o;
  logic [NDEV-1:0]      d_cs_o;
  logic                 d_cyc_o;
  logic                 d_stb_o;
  logic                 d_we_o;
  logic [3:0]           d_sel_o;
  logic [15:0]          d_adr_o;
  logic [31:0]          d_dat_o;
  logic [NDEV-1:0]      d_ack_i;
  logic [NDEV*32-1:0]   d_dat_i;
  logic                 err_o;

  modport slave (
    input  s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, d_ack_i, d_dat_i,
    output s_ack_o, s_stall_o, s_dat_o, d_cs_o, d_cyc_o, d_stb_o, d_we_o,
           d_sel_o, d_adr_o, d_dat_o, err_o
  );

  modport master (
    output s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, d_ack_i, d_dat_i,
    input  s_ack_o, s_stall_o, s_dat_o, d_cs_o, d_cyc_o, d_stb_o, d_we_o,
           d_sel_o, d_adr_o, d_dat_o, err_o
  );
endinterface

// File: rtl/av_dev_demux.sv
// Address demux from one upstream bus to NDEV device slots (adr[18:16] picks the slot).
// Optional ack timeout enabled by the macro AVDEMUX_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a request, not stalled
// ACTIVE | device cycle open on slot, waiting for its ack (or abort/timeout)
// ACK    | upstream ack held until s_stb_i drops
module av_dev_demux #(
  parameter int          NDEV   = 4,
  parameter logic [11:0] BASE   = 12'hFD0,
  parameter int          TO_CYC = 255
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  av_dev_demux_if.slave  bus
);
  if (NDEV < 2 || NDEV > 8 || TO_CYC < 1 || TO_CYC > 255) begin : g_param_chk
    $error("av_dev_demux: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, ACK} state_t;

  state_t          state_q, state_d;
  logic [NDEV-1:0] cs_q, cs_d;
  logic            dcyc_q, dcyc_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [15:0]     adr_q, adr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdat_q, rdat_d;
  logic            err_q, err_d;
  logic            mapped, dev_ack, tmo, clr_dev;
  logic [31:0]     dev_dat;

  // cs_q is one-hot on the open slot, so it alone selects which ack/data is honoured
  always_comb begin
    dev_ack = 1'b0;
    dev_dat = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (cs_q[k]) begin
        dev_ack = bus.d_ack_i[k];
        dev_dat = bus.d_dat_i[32*k +: 32];
      end
    end
  end

`ifdef AVDEMUX_TIMEOUT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 cnt_q <= '0;
    else if (state_q != ACTIVE)  cnt_q <= '0;
    else if (cnt_q != 8'hFF)     cnt_q <= cnt_q + 8'd1;
  end
  assign tmo = (state_q == ACTIVE) && (cnt_q == 8'(TO_CYC));
`else
  assign tmo = 1'b0;
`endif

  assign mapped = (bus.s_adr_i[31:20] == BASE) && (32'(bus.s_adr_i[18:16]) < NDEV);

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    dcyc_d  = dcyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    ack_d   = ack_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    clr_dev = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.s_cyc_i && bus.s_stb_i) begin
          if (mapped) begin
            state_d = ACTIVE;
            dcyc_d  = 1'b1;
            we_d    = bus.s_we_i;
            sel_d   = bus.s_sel_i;
            adr_d   = bus.s_adr_i[15:0];
            wdat_d  = bus.s_dat_i;
            for (int k = 0; k < NDEV; k++) cs_d[k] = (bus.s_adr_i[18:16] == 3'(k));
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
            rdat_d  = '0;
          end
        end
      end
      ACTIVE: begin
        // abort outranks a same-cycle ack, and an ack outranks a same-cycle timeout
        if (!bus.s_cyc_i) begin
          state_d = IDLE;
          clr_dev = 1'b1;
        end else if (dev_ack) begin
          state_d = ACK;
          ack_d   = 1'b1;
          rdat_d  = we_q ? 32'h0 : dev_dat;
          clr_dev = 1'b1;
        end else if (tmo) begin
          state_d = ACK;
          ack_d   = 1'b1;
          rdat_d  = 32'hDEAD_DEAD;
          err_d   = 1'b1;
          clr_dev = 1'b1;
        end
      end
      ACK: begin
        if (!bus.s_stb_i) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          rdat_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_dev) begin
      cs_d   = '0;
      dcyc_d = 1'b0;
      we_d   = 1'b0;
      sel_d  = '0;
      adr_d  = '0;
      wdat_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cs_q    <= '0;
      dcyc_q  <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      dcyc_q  <= dcyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_ack_o   = ack_q;
  assign bus.s_stall_o = (state_q != IDLE);
  assign bus.s_dat_o   = rdat_q;
  assign bus.d_cs_o    = cs_q;
  assign bus.d_cyc_o   = dcyc_q;
  assign bus.d_stb_o   = dcyc_q;
  assign bus.d_we_o    = we_q;
  assign bus.d_sel_o   = sel_q;
  assign bus.d_adr_o   = adr_q;
  assign bus.d_dat_o   = wdat_q;
  assign bus.err_o     = err_q;
endmodule

// File: doc/av_dev_demux.md
AV_DEV_DEMUX -- requirements
Module: av_dev_demux

Interface
REQ-001 SHALL have parameter NDEV, default 4, meaning number of device slots (2..8).
REQ-002 SHALL have parameter BASE, default 12'hFD0, meaning the adr[31:20] value that selects this block.
REQ-003 SHALL have parameter TO_CYC, default 255, meaning the device-ack timeout in clocks (1..255).
REQ-004 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  async active-low reset.
- s_cyc_i, s_stb_i, s_we_i  in  1 each  upstream bus cycle, strobe and write.
- s_sel_i  in  4  byte selects.
- s_adr_i  in  32  address.
- s_dat_i  in  32  write data.
- s_ack_o  out  1  ack to upstream.
- s_stall_o  out  1  busy.
- s_dat_o  out  32  read data.
- d_cs_o  out  NDEV  one-hot device select.
- d_cyc_o, d_stb_o, d_we_o  out  1 each  device cycle, strobe and write.
- d_sel_o  out  4  device byte selects.
- d_adr_o  out  16  device offset.
- d_dat_o  out  32  device write data.
- d_ack_i  in  NDEV  per-device ack.
- d_dat_i  in  NDEV*32  per-device read data; slot k uses bits [32k+31:32k].
- err_o  out  1  timeout indication.

Function
REQ-006 States SHALL be IDLE, ACTIVE and ACK; s_stall_o=1 in every state except IDLE.
REQ-007 In IDLE with s_cyc_i & s_stb_i, the block SHALL register we, sel, dat and adr[15:0], and compute slot = adr[18:16].
REQ-008 A request SHALL be mapped iff adr[31:20]==BASE && slot<NDEV.
REQ-009 Mapped request: on the next clock the block SHALL assert d_cs_o[slot], d_cyc_o and d_stb_o with the registered fields, and enter ACTIVE.
REQ-010 Unmapped request: on the next clock the block SHALL assert s_ack_o with s_dat_o=0, drive no d_* cycle, and enter ACK.
REQ-011 In ACTIVE, only d_ack_i[slot] SHALL be honoured; ack bits of other slots SHALL be ignored.
REQ-012 When d_ack_i[slot]=1 in ACTIVE, on the next clock the block SHALL:
- set s_ack_o=1;
- set s_dat_o to the selected slot's data (reads) or 0 (writes);
- clear d_cs_o, d_cyc_o, d_stb_o, d_we_o, d_sel_o, d_adr_o and d_dat_o;
- enter ACK.
REQ-013 Read latency SHALL be 2 clocks plus the device wait states, measured from request sample to s_ack_o.
REQ-014 In ACK, s_ack_o and s_dat_o SHALL hold until s_stb_i=0; on that clock s_ack_o and s_dat_o SHALL return to 0 on the next edge and the state SHALL return to IDLE.
REQ-015 Abort: if s_cyc_i=0 in ACTIVE, the block SHALL clear the d_* signals, give no ack and return to IDLE on the next clock.
REQ-016 If abort and d_ack_i[slot] occur on the same clock, the abort SHALL win and no ack SHALL be issued.
REQ-017 A new request SHALL be accepted no earlier than the clock after the return to IDLE; back-to-back requests SHALL NOT overlap.

Reset
REQ-018 While rst_ni=0, the block SHALL hold:
- state=IDLE;
- s_ack_o=0, s_stall_o=0, s_dat_o=0;
- d_cs_o=0, d_cyc_o=0, d_stb_o=0, d_we_o=0, d_sel_o=0, d_adr_o=0, d_dat_o=0;
- err_o=0;
- timeout counter=0.
REQ-019 Reset asserted mid-cycle SHALL drop all outputs immediately and asynchronously, with no ack generated after release.

Configuration
REQ-020 Macro AVDEMUX_TIMEOUT_EN SHALL control the timeout feature.
REQ-021 With AVDEMUX_TIMEOUT_EN defined, the timeout SHALL work as follows:
- an 8-bit counter clears on entry to ACTIVE and increments each clock in ACTIVE;
- when it reaches TO_CYC without an ack, on the next clock s_ack_o=1, s_dat_o=32'hDEADDEAD, err_o=1, d_* clear, state ACK;
- err_o holds until ACK exits.
REQ-022 Without AVDEMUX_TIMEOUT_EN, there SHALL be no counter, err_o SHALL be tied 0, and ACTIVE SHALL wait indefinitely for an ack or an abort.

Verification
REQ-023 Read adr=32'hFD02_0010, device 2 acks at cycle 3 with 32'h1234_5678 -> d_cs_o=4'b0100, d_adr_o=16'h0010, s_ack_o at cycle 4, s_dat_o=32'h1234_5678.
REQ-024 Write adr=32'hFD01_0004, dat=32'hA5A5_A5A5, sel=4'hF -> d_cs_o=4'b0010, d_we_o=1, d_dat_o=32'hA5A5_A5A5; after the ack, s_dat_o=0; s_ack_o drops the clock after s_stb_i falls.
REQ-025 Read adr=32'hFE00_0000 (unmapped) and adr=32'hFD05_0000 (slot>=NDEV) -> d_cyc_o stays 0, s_ack_o=1 one clock after the request, s_dat_o=0.
REQ-026 Slot 0 active and d_ack_i=4'b1000 (wrong slot) -> no s_ack_o; then d_ack_i=4'b0001 -> s_ack_o next clock.
REQ-027 s_cyc_i dropped in ACTIVE, including the same clock as d_ack_i -> no s_ack_o, d_cyc_o=0 next clock, state IDLE; rst_ni pulsed mid-ACTIVE -> all outputs 0 at once.
REQ-028 AVDEMUX_TIMEOUT_EN, TO_CYC=4, device silent -> s_ack_o=1, s_dat_o=32'hDEADDEAD, err_o=1 on the 6th clock after the request; without the macro, the bus stays pending after 300 clocks.
